comp_share_arb: RTL

//   Shares one DATA_WIDTH magnitude comparator between two requesters.

---
 rtl/comp_share_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/comp_share_arb.sv
// One magnitude comparator shared round-robin by two requesters: grant, compare, respond.
// Define COMP_SHARE_SIGNED_EN to compare operands as two's complement instead of unsigned.
module comp_share_arb #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] b0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] b1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  res_valid,
    output logic                  res_id,
    output logic                  gt,
    output logic                  lt,
    output logic                  eq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    last_id_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    gnt0_q;
    logic                    gnt1_q;
    logic                    res_valid_q;
    logic                    res_id_q;
    logic                    gt_q;
    logic                    lt_q;
    logic                    eq_q;

    logic                    win_d;
    logic [DATA_WIDTH-1:0]   a_d;
    logic [DATA_WIDTH-1:0]   b_d;
    logic                    gt_d;
    logic                    lt_d;
    logic                    eq_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win_d = 1'b0;
        if (req0 && req1) begin
            win_d = ~last_id_q;
        end else begin
            win_d = req1;
        end
        a_d = win_d ? a1 : a0;
        b_d = win_d ? b1 : b0;
    end

    always_comb begin
        eq_d = (a_q == b_q);
`ifdef COMP_SHARE_SIGNED_EN
        gt_d = ($signed(a_q) > $signed(b_q));
        lt_d = ($signed(a_q) < $signed(b_q));
`else
        gt_d = (a_q > b_q);
        lt_d = (a_q < b_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        a_q       <= a_d;
                        b_q       <= b_d;
                        last_id_q <= win_d;
                        gnt0_q    <= ~win_d;
                        gnt1_q    <= win_d;
                        state_q   <= CMP;
                    end
                end
                CMP: begin
                    gt_q        <= gt_d;
                    lt_q        <= lt_d;
                    eq_q        <= eq_d;
                    res_id_q    <= last_id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Spacer cycle so grants are at least three clocks apart.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;

endmodule
